// File: rtl/vga_pic_bounce.sv
// ----------------------------------------------------------------------------
// vga_pic_bounce
//   Picture generator placed in front of the VGA timing/DAC stage. Draws eight
//   vertical colour bars across the active area with a solid square on top.
//   The square moves once per frame, bounces off the screen edges and steps to
//   the next palette colour on every bounce.
//
// Ports
//   vga_clk    in   1   pixel clock (only clock in the block)
//   sys_rst_n  in   1   asynchronous active-low reset
//   pix_x      in  10   active column, 10'h3FF while blanked
//   pix_y      in  10   active row,    10'h3FF while blanked
//   pix_data   out 24   registered RGB888 {R,G,B}, one pixel per clock
// ----------------------------------------------------------------------------
module vga_pic_bounce #(
    parameter int H_VALID = 640,
    parameter int V_VALID = 480,
    parameter int SQ_SIZE = 40,
    parameter int STEP_X  = 2,
    parameter int STEP_Y  = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [23:0] pix_data
);

    // All comparisons run in 11 bits so that position + size/step cannot wrap.
    localparam logic [10:0] H_VALID_W = 11'(H_VALID);
    localparam logic [10:0] V_VALID_W = 11'(V_VALID);
    localparam logic [10:0] BAR_W_W   = 11'(H_VALID / 8);
    localparam logic [10:0] SQ_W      = 11'(SQ_SIZE);
    localparam logic [10:0] STEP_X_W  = 11'(STEP_X);
    localparam logic [10:0] STEP_Y_W  = 11'(STEP_Y);
    localparam logic [10:0] MAX_X_W   = 11'(H_VALID - SQ_SIZE);
    localparam logic [10:0] MAX_Y_W   = 11'(V_VALID - SQ_SIZE);
    localparam logic [9:0]  STEP_X_P  = 10'(STEP_X);
    localparam logic [9:0]  STEP_Y_P  = 10'(STEP_Y);
    localparam logic [9:0]  MAX_X_P   = 10'(H_VALID - SQ_SIZE);
    localparam logic [9:0]  MAX_Y_P   = 10'(V_VALID - SQ_SIZE);

    // Eight-entry colour table shared by the bars and the square.
    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            3'd7:    rgb = 24'h000000;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    logic [9:0]  sq_x_q, sq_x_d;
    logic [9:0]  sq_y_q, sq_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [2:0]  col_idx_q, col_idx_d;
    logic [23:0] pix_data_q, pix_data_d;

    logic [10:0] px_s, py_s, sqx_s, sqy_s;
    logic [10:0] bar_full_s;
    logic [2:0]  bar_idx_s;
    logic        active_s, hit_s, tick_s;
    logic        bounce_x_s, bounce_y_s;

    assign px_s  = {1'b0, pix_x};
    assign py_s  = {1'b0, pix_y};
    assign sqx_s = {1'b0, sq_x_q};
    assign sqy_s = {1'b0, sq_y_q};

    // Pixel classification: active area, square hit, frame tick, bar index.
    always_comb begin
        active_s   = (px_s < H_VALID_W) && (py_s < V_VALID_W);
        hit_s      = (px_s >= sqx_s) && (px_s < sqx_s + SQ_W) &&
                     (py_s >= sqy_s) && (py_s < sqy_s + SQ_W);
        tick_s     = (px_s == H_VALID_W - 11'd1) && (py_s == V_VALID_W - 11'd1);
        bar_full_s = px_s / BAR_W_W;
        if (bar_full_s > 11'd7) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_full_s[2:0];
        end
    end

    // Colour selection: blanking wins, then the square, then the bar.
    always_comb begin
        pix_data_d = 24'h000000;
        if (!active_s) begin
            pix_data_d = 24'h000000;
        end else if (hit_s) begin
            pix_data_d = palette(col_idx_q);
        end else begin
            pix_data_d = palette(bar_idx_s);
        end
    end

    // Square motion: one step per frame tick, clamping to the edge on a bounce.
    always_comb begin
        sq_x_d     = sq_x_q;
        sq_y_d     = sq_y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        col_idx_d  = col_idx_q;
        bounce_x_s = 1'b0;
        bounce_y_s = 1'b0;
        if (tick_s) begin
            if (dir_x_q) begin
                if (sqx_s + STEP_X_W >= MAX_X_W) begin
                    sq_x_d     = MAX_X_P;
                    dir_x_d    = 1'b0;
                    bounce_x_s = 1'b1;
                end else begin
                    sq_x_d = sq_x_q + STEP_X_P;
                end
            end else begin
                if (sqx_s <= STEP_X_W) begin
                    sq_x_d     = 10'd0;
                    dir_x_d    = 1'b1;
                    bounce_x_s = 1'b1;
                end else begin
                    sq_x_d = sq_x_q - STEP_X_P;
                end
            end
            if (dir_y_q) begin
                if (sqy_s + STEP_Y_W >= MAX_Y_W) begin
                    sq_y_d     = MAX_Y_P;
                    dir_y_d    = 1'b0;
                    bounce_y_s = 1'b1;
                end else begin
                    sq_y_d = sq_y_q + STEP_Y_P;
                end
            end else begin
                if (sqy_s <= STEP_Y_W) begin
                    sq_y_d     = 10'd0;
                    dir_y_d    = 1'b1;
                    bounce_y_s = 1'b1;
                end else begin
                    sq_y_d = sq_y_q - STEP_Y_P;
                end
            end
            // A corner hit bounces both axes but is still a single colour step.
            if (bounce_x_s || bounce_y_s) begin
                col_idx_d = col_idx_q + 3'd1;
            end else begin
                col_idx_d = col_idx_q;
            end
        end else begin
            sq_x_d = sq_x_q;
        end
    end

    // State and output registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_q <= 24'h000000;
            sq_x_q     <= 10'd0;
            sq_y_q     <= 10'd0;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            col_idx_q  <= 3'd0;
        end else begin
            pix_data_q <= pix_data_d;
            sq_x_q     <= sq_x_d;
            sq_y_q     <= sq_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            col_idx_q  <= col_idx_d;
        end
    end

    assign pix_data = pix_data_q;

endmodule

// File: tb/tb_vga_pic_bounce.sv
`timescale 1ns/1ps
// Bench for vga_pic_bounce: directed pixels with hand-computed colours.
// Stimulus pushes expectations into a scoreboard; a monitor on the falling
// edge pops and compares them against the registered output.
module tb_vga_pic_bounce;

    logic        clk;
    logic        sys_rst_n;
    logic [9:0]  px, py, px2, py2;
    logic [23:0] pd, pd2;
    int          cyc;

    int          n_cmp;
    int          n_bad;

    int          due_q[$];
    bit          sel_q[$];
    bit          use_act_q[$];
    logic [23:0] act_q[$];
    logic [23:0] exp_q[$];
    string       name_q[$];

    vga_pic_bounce dut (
        .vga_clk  (clk),
        .sys_rst_n(sys_rst_n),
        .pix_x    (px),
        .pix_y    (py),
        .pix_data (pd)
    );

    vga_pic_bounce #(
        .H_VALID(160), .V_VALID(160), .SQ_SIZE(40), .STEP_X(2), .STEP_Y(2)
    ) dut2 (
        .vga_clk  (clk),
        .sys_rst_n(sys_rst_n),
        .pix_x    (px2),
        .pix_y    (py2),
        .pix_data (pd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_cmp = 0;
        n_bad = 0;
    end

    // Monitor: compare every expectation whose output cycle has arrived.
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            logic [23:0] act;
            if (use_act_q[0]) act = act_q[0];
            else if (sel_q[0]) act = pd2;
            else act = pd;
            n_cmp = n_cmp + 1;
            if (act !== exp_q[0]) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %h expected %h", name_q[0], act, exp_q[0]);
            end
            void'(due_q.pop_front());
            void'(sel_q.pop_front());
            void'(use_act_q.pop_front());
            void'(act_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    task automatic push_exp(input int due, input bit sel, input bit use_act,
                            input logic [23:0] act, input logic [23:0] e, input string nm);
        due_q.push_back(due);
        sel_q.push_back(sel);
        use_act_q.push_back(use_act);
        act_q.push_back(act);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Present one pixel; optionally expect its colour one clock later.
    task automatic drive(input bit sel, input logic [9:0] x, input logic [9:0] y,
                         input bit chk, input logic [23:0] e, input string nm);
        @(negedge clk);
        if (sel) begin
            px2 = x;
            py2 = y;
        end else begin
            px = x;
            py = y;
        end
        if (chk) push_exp(cyc + 1, sel, 1'b0, 24'h000000, e, nm);
    endtask

    task automatic ticks(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) drive(1'b1, 10'd159, 10'd159, 1'b0, 24'h000000, "");
            else     drive(1'b0, 10'd639, 10'd479, 1'b0, 24'h000000, "");
        end
    endtask

    initial begin
        logic [23:0] snap;
        sys_rst_n = 1'b0;
        px  = 10'h3FF; py  = 10'h3FF;
        px2 = 10'h3FF; py2 = 10'h3FF;
        repeat (2) @(negedge clk);

        // Reset held with a mid-frame pixel on the inputs.
        drive(1'b0, 10'd320, 10'd240, 1'b1, 24'h000000, "rst_hold");
        @(posedge clk);
        #1 sys_rst_n = 1'b1;

        // Background bars and blanking.
        drive(1'b0, 10'd10,   10'd10,   1'b1, 24'hFFFFFF, "bar0_white");
        drive(1'b0, 10'd100,  10'd10,   1'b1, 24'hFFFF00, "bar1_yellow");
        drive(1'b0, 10'd639,  10'd200,  1'b1, 24'h000000, "bar7_black");
        drive(1'b0, 10'd320,  10'd240,  1'b1, 24'hFF00FF, "bar4_magenta");
        drive(1'b0, 10'h3FF,  10'd5,    1'b1, 24'h000000, "blank_x");
        drive(1'b0, 10'd5,    10'h3FF,  1'b1, 24'h000000, "blank_y");

        // 150 ticks: square at (300,300), still white.
        ticks(1'b0, 150);
        drive(1'b0, 10'd300, 10'd300, 1'b1, 24'hFFFFFF, "sq150_in");
        drive(1'b0, 10'd299, 10'd300, 1'b1, 24'h00FF00, "sq150_left");
        drive(1'b0, 10'd340, 10'd300, 1'b1, 24'hFF00FF, "sq150_right");

        // Asynchronous reset in the middle of a line.
        drive(1'b0, 10'd100, 10'd200, 1'b0, 24'h000000, "");
        #2 sys_rst_n = 1'b0;
        #1 snap = pd;
        push_exp(cyc, 1'b0, 1'b1, snap, 24'h000000, "async_rst");
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        drive(1'b0, 10'd300, 10'd300, 1'b1, 24'h00FF00, "rst_pos_gone");
        drive(1'b0, 10'd10,  10'd10,  1'b1, 24'hFFFFFF, "rst_px10");

        // Bottom bounce on tick 220: square (440,440), colour 1.
        ticks(1'b0, 220);
        drive(1'b0, 10'd440, 10'd440, 1'b1, 24'hFFFF00, "bottom_sq");
        drive(1'b0, 10'd439, 10'd440, 1'b1, 24'hFF0000, "bottom_left");
        drive(1'b0, 10'd479, 10'd479, 1'b1, 24'hFFFF00, "bottom_last");
        drive(1'b0, 10'd480, 10'd479, 1'b1, 24'h0000FF, "bottom_right");

        // Right bounce on tick 300: square (600,280), colour 2.
        ticks(1'b0, 80);
        drive(1'b0, 10'd600, 10'd290, 1'b1, 24'h00FFFF, "right_sq");
        drive(1'b0, 10'd599, 10'd290, 1'b1, 24'h000000, "right_left");
        drive(1'b0, 10'd639, 10'd319, 1'b1, 24'h00FFFF, "right_edge");
        drive(1'b0, 10'd639, 10'd320, 1'b1, 24'h000000, "right_below");

        // Tick 301: square moves back left to (598,278).
        ticks(1'b0, 1);
        drive(1'b0, 10'd598, 10'd278, 1'b1, 24'h00FFFF, "after_sq");
        drive(1'b0, 10'd597, 10'd278, 1'b1, 24'h000000, "after_left");
        drive(1'b0, 10'd598, 10'd277, 1'b1, 24'h000000, "after_above");

        // Corner on the 160x160 instance: tick 60 bounces both axes.
        ticks(1'b1, 59);
        drive(1'b1, 10'd118, 10'd118, 1'b1, 24'hFFFFFF, "pre_corner_sq");
        drive(1'b1, 10'd117, 10'd118, 1'b1, 24'hFF0000, "pre_corner_bg");
        ticks(1'b1, 1);
        drive(1'b1, 10'd120, 10'd120, 1'b1, 24'hFFFF00, "corner_sq");
        drive(1'b1, 10'd119, 10'd120, 1'b1, 24'hFF0000, "corner_bg");
        ticks(1'b1, 1);
        drive(1'b1, 10'd118, 10'd118, 1'b1, 24'hFFFF00, "corner_once");
        drive(1'b1, 10'd157, 10'd157, 1'b1, 24'hFFFF00, "corner_far");
        drive(1'b1, 10'd158, 10'd158, 1'b1, 24'h000000, "corner_out");

        // Reset again after bounces: colour index returns to white.
        @(negedge clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        ticks(1'b0, 40);
        drive(1'b0, 10'd80,  10'd80, 1'b1, 24'hFFFFFF, "col_reset_sq");
        drive(1'b0, 10'd120, 10'd80, 1'b1, 24'hFFFF00, "col_reset_bg");

        // Let the scoreboard drain, bounded.
        for (int i = 0; i < 10 && due_q.size() > 0; i++) @(negedge clk);
        if (due_q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d left, expected 0", due_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
